// File: rtl/sseg_pkg.sv
// Shared constants, types and helpers for the seven-segment I/O register block.
package sseg_pkg;

    // Register word indices, matched against io_addr[3:2].
    localparam logic [1:0] ADDR_VALUE  = 2'd0;  // byte address 0x0
    localparam logic [1:0] ADDR_CTRL   = 2'd1;  // byte address 0x4
    localparam logic [1:0] ADDR_STATUS = 2'd2;  // byte address 0x8

    // Largest value shown in decimal mode; larger values saturate to 99999999.
    localparam logic [31:0] MAX_DEC = 32'd99999999;

    // Saturated display pattern.
    localparam logic [31:0] BCD_SAT = 32'h9999_9999;

    // STATUS register bit positions.
    localparam int STATUS_BUSY = 0;
    localparam int STATUS_OVF  = 1;

    // Double-dabble engine states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } dd_state_e;

    // Expand a 4-bit byte-enable into a 32-bit bit mask.
    function automatic logic [31:0] expand_mask(input logic [3:0] wmask);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{wmask[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Sequential double-dabble converter: 32-bit binary to 8-digit packed BCD.
// A start pulse always (re)loads the engine, discarding any conversion in
// flight; values above MAX_DEC skip the shift phase and report saturation.
module bin2bcd_dd #(
    parameter logic [31:0] MAX_DEC = sseg_pkg::MAX_DEC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] bin_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] bcd_out,
    output logic        ovf
);
    import sseg_pkg::*;

    dd_state_e   state;
    logic [31:0] bin_q;
    logic [31:0] bcd_q;
    logic [4:0]  cnt;
    logic [31:0] bcd_adj;

    // Add-3 correction on every BCD digit that is 5 or more before the shift.
    always_comb begin
        // NOTE: default assignment first so every path drives every bit and no latch is inferred.
        bcd_adj = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM: load on start, 32 shift steps, one DONE cycle.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= ST_IDLE;
            bin_q <= '0;
            bcd_q <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (start) begin
            cnt <= '0;
            if (bin_in > MAX_DEC) begin
                bin_q <= '0;
                bcd_q <= BCD_SAT;
                ovf   <= 1'b1;
                state <= ST_DONE;
            end else begin
                bin_q <= bin_in;
                bcd_q <= '0;
                ovf   <= 1'b0;
                state <= ST_SHIFT;
            end
        end else if (abort) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    cnt            <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);
    assign bcd_out = bcd_q;

endmodule

// File: rtl/sseg_io_regs.sv
// Memory-mapped VALUE/CTRL/STATUS registers feeding the seven-segment scanner.
// In hex mode num mirrors VALUE; in decimal mode num receives the BCD result
// of the double-dabble engine, updated only when a conversion completes.
module sseg_io_regs #(
    parameter int          ADDR_W  = 4,
    parameter logic [31:0] MAX_DEC = sseg_pkg::MAX_DEC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_wr_en,
    input  logic              io_rd_en,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [31:0]       io_wdata,
    input  logic [3:0]        io_wmask,
    output logic [31:0]       io_rdata,
    output logic [31:0]       num
);
    import sseg_pkg::*;

    logic [31:0] value_reg;
    logic        dec;
    logic        ovf_reg;

    logic [1:0]  word_sel;
    logic [31:0] merged;
    logic        wr_value;
    logic        wr_ctrl;
    logic        dec_rise;
    logic        dec_fall;

    logic        eng_start;
    logic        eng_abort;
    logic [31:0] eng_bin;
    logic        eng_busy;
    logic        eng_done;
    logic [31:0] eng_bcd;
    logic        eng_ovf;

    // Byte offset within a word carries no meaning for this block.
    logic        unused_addr;
    assign unused_addr = ^io_addr[1:0];

    assign word_sel = io_addr[3:2];
    assign merged   = (value_reg & ~expand_mask(io_wmask)) | (io_wdata & expand_mask(io_wmask));
    assign wr_value = io_wr_en && (word_sel == ADDR_VALUE);
    assign wr_ctrl  = io_wr_en && (word_sel == ADDR_CTRL) && io_wmask[0];
    assign dec_rise = wr_ctrl && io_wdata[0] && !dec;
    assign dec_fall = wr_ctrl && !io_wdata[0] && dec;

    // Entering decimal mode converts whatever VALUE already holds.
    assign eng_start = (wr_value && dec) || dec_rise;
    assign eng_bin   = dec_rise ? value_reg : merged;
    assign eng_abort = dec_fall;

    bin2bcd_dd #(
        .MAX_DEC (MAX_DEC)
    ) u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .start   (eng_start),
        .abort   (eng_abort),
        .bin_in  (eng_bin),
        .busy    (eng_busy),
        .done    (eng_done),
        .bcd_out (eng_bcd),
        .ovf     (eng_ovf)
    );

    // VALUE and CTRL register writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_reg <= '0;
            dec       <= 1'b0;
        end else begin
            if (wr_value) begin
                value_reg <= merged;
            end
            if (wr_ctrl) begin
                dec <= io_wdata[0];
            end
        end
    end

    // Display value and overflow flag; a restart in the same edge suppresses a stale result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num     <= '0;
            ovf_reg <= 1'b0;
        end else if (wr_value && !dec) begin
            num     <= merged;
            ovf_reg <= 1'b0;
        end else if (dec_fall) begin
            num     <= value_reg;
            ovf_reg <= 1'b0;
        end else if (eng_done && !eng_start) begin
            num     <= eng_bcd;
            ovf_reg <= eng_ovf;
        end
    end

    // Registered read port; returns pre-write contents on a simultaneous write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_rdata <= '0;
        end else if (io_rd_en) begin
            case (word_sel)
                ADDR_VALUE:  io_rdata <= value_reg;
                ADDR_CTRL:   io_rdata <= {31'b0, dec};
                ADDR_STATUS: begin
                    io_rdata              <= '0;
                    io_rdata[STATUS_BUSY] <= eng_busy;
                    io_rdata[STATUS_OVF]  <= ovf_reg;
                end
                default:     io_rdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sseg_io_regs.sv
// Self-checking bench for sseg_io_regs with a cycle-level behavioural model.
module tb_sseg_io_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_wr_en = 1'b0;
    logic        io_rd_en = 1'b0;
    logic [3:0]  io_addr = 4'h0;
    logic [31:0] io_wdata = '0;
    logic [3:0]  io_wmask = 4'h0;
    logic [31:0] io_rdata;
    logic [31:0] num;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [31:0] m_value, m_num, m_pend, m_rdata;
    logic        m_dec, m_ovf, m_pend_ovf;
    int          m_cnt;  // edges remaining until the pending result lands on num

    sseg_io_regs dut (
        .clk      (clk),
        .reset    (reset),
        .io_wr_en (io_wr_en),
        .io_rd_en (io_rd_en),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_wmask (io_wmask),
        .io_rdata (io_rdata),
        .num      (num)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] to_bcd(input logic [31:0] v);
        logic [31:0] r = '0;
        int unsigned x = v;
        for (int i = 0; i < 8; i++) begin
            r = r | ((x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_value = '0; m_num = '0; m_pend = '0; m_rdata = '0;
        m_dec = 1'b0; m_ovf = 1'b0; m_pend_ovf = 1'b0; m_cnt = 0;
    endtask

    task automatic model_start(input logic [31:0] v);
        if (v > 32'd99999999) begin
            m_pend = 32'h9999_9999; m_pend_ovf = 1'b1; m_cnt = 1;
        end else begin
            m_pend = to_bcd(v); m_pend_ovf = 1'b0; m_cnt = 33;
        end
    endtask

    task automatic model_edge(input logic wr, input logic rd, input logic [3:0] addr,
                              input logic [31:0] wd, input logic [3:0] wm);
        logic [31:0] mask, merged;
        bit acted = 0;
        if (rd) begin
            case (addr[3:2])
                2'd0: m_rdata = m_value;
                2'd1: m_rdata = {31'b0, m_dec};
                2'd2: m_rdata = {30'b0, m_ovf, (m_cnt != 0)};
                default: m_rdata = '0;
            endcase
        end
        if (wr && addr[3:2] == 2'd0) begin
            for (int i = 0; i < 4; i++) mask[8*i +: 8] = wm[i] ? 8'hFF : 8'h00;
            merged  = (m_value & ~mask) | (wd & mask);
            m_value = merged;
            acted   = 1;
            if (m_dec) model_start(merged);
            else begin m_num = merged; m_ovf = 1'b0; m_cnt = 0; end
        end else if (wr && addr[3:2] == 2'd1 && wm[0] && wd[0] != m_dec) begin
            acted = 1;
            if (wd[0]) model_start(m_value);
            else begin m_cnt = 0; m_num = m_value; m_ovf = 1'b0; end
            m_dec = wd[0];
        end
        if (!acted && m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin m_num = m_pend; m_ovf = m_pend_ovf; end
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, release strobes.
    task automatic step(input logic wr, input logic rd, input logic [3:0] addr,
                        input logic [31:0] wd, input logic [3:0] wm);
        io_wr_en = wr; io_rd_en = rd; io_addr = addr; io_wdata = wd; io_wmask = wm;
        @(posedge clk);
        model_edge(wr, rd, addr, wd, wm);
        #1;
        io_wr_en = 1'b0; io_rd_en = 1'b0;
    endtask

    task automatic idle(); step(0, 0, 4'h0, '0, 4'h0); endtask

    task automatic test_reset();
        reset = 1'b1; model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        total++; if (num !== 32'h0) begin bad++; $display("FAIL reset_num got=%h exp=%h", num, 32'h0); end
        total++; if (io_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", io_rdata, 32'h0); end
        step(0, 1, 4'h8, '0, 4'h0);
        total++; if (io_rdata !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=%h", io_rdata, 32'h0); end
    endtask

    task automatic test_hex_write();
        step(1, 0, 4'h0, 32'hDEAD_BEEF, 4'hF);
        total++; if (num !== 32'hDEAD_BEEF) begin bad++; $display("FAIL hex_num got=%h exp=%h", num, 32'hDEAD_BEEF); end
        step(0, 1, 4'h0, '0, 4'h0);
        total++; if (io_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL hex_read got=%h exp=%h", io_rdata, 32'hDEAD_BEEF); end
    endtask

    task automatic test_byte_mask();
        step(1, 0, 4'h0, 32'h1234_5678, 4'hF);
        step(1, 0, 4'h0, 32'h0000_AB00, 4'b0010);
        total++; if (num !== 32'h1234_AB78) begin bad++; $display("FAIL mask_num got=%h exp=%h", num, 32'h1234_AB78); end
        step(0, 1, 4'h4, '0, 4'h0);
        total++; if (io_rdata !== 32'h0) begin bad++; $display("FAIL mask_ctrl got=%h exp=%h", io_rdata, 32'h0); end
        // simultaneous write and read of VALUE returns the old contents
        step(1, 1, 4'h0, 32'hCAFE_0001, 4'hF);
        total++; if (io_rdata !== 32'h1234_AB78) begin bad++; $display("FAIL rw_same_cycle got=%h exp=%h", io_rdata, 32'h1234_AB78); end
        total++; if (num !== 32'hCAFE_0001) begin bad++; $display("FAIL rw_num got=%h exp=%h", num, 32'hCAFE_0001); end
    endtask

    task automatic test_decimal();
        logic [31:0] old_num;
        step(1, 0, 4'h4, 32'h0, 4'h1);       // make sure dec is 0 first
        step(1, 0, 4'h0, 32'h0, 4'hF);
        step(1, 0, 4'h4, 32'h1, 4'h1);       // dec 0->1 converts 0
        repeat (34) idle();
        old_num = num;
        step(1, 0, 4'h0, 32'h00BC_614E, 4'hF);
        for (int k = 1; k <= 33; k++) begin
            step(0, 1, 4'h8, '0, 4'h0);      // STATUS sampled pre-edge T+k
            total++; if (io_rdata !== m_rdata || io_rdata[0] !== 1'b1) begin bad++; $display("FAIL dec_busy k=%0d got=%h exp=%h", k, io_rdata, m_rdata); end
            if (k < 33) begin
                total++; if (num !== old_num) begin bad++; $display("FAIL dec_hold k=%0d got=%h exp=%h", k, num, old_num); end
            end
        end
        total++; if (num !== 32'h1234_5678) begin bad++; $display("FAIL dec_num got=%h exp=%h", num, 32'h1234_5678); end
        step(0, 1, 4'h8, '0, 4'h0);
        total++; if (io_rdata !== 32'h0) begin bad++; $display("FAIL dec_idle got=%h exp=%h", io_rdata, 32'h0); end
    endtask

    task automatic test_saturation();
        step(1, 0, 4'h0, 32'd100000000, 4'hF);
        idle();
        total++; if (num !== 32'h9999_9999) begin bad++; $display("FAIL sat_num got=%h exp=%h", num, 32'h9999_9999); end
        step(0, 1, 4'h8, '0, 4'h0);
        total++; if (io_rdata !== 32'h2) begin bad++; $display("FAIL sat_status got=%h exp=%h", io_rdata, 32'h2); end
        step(1, 0, 4'h0, 32'd42, 4'hF);
        repeat (33) idle();
        total++; if (num !== 32'h0000_0042) begin bad++; $display("FAIL sat_clear_num got=%h exp=%h", num, 32'h42); end
        step(0, 1, 4'h8, '0, 4'h0);
        total++; if (io_rdata !== 32'h0) begin bad++; $display("FAIL sat_clear_status got=%h exp=%h", io_rdata, 32'h0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] old_num = num;
        step(1, 0, 4'h0, 32'd1000, 4'hF);
        repeat (9) idle();
        step(1, 0, 4'h0, 32'd2500, 4'hF);    // restart ten cycles later
        for (int k = 1; k <= 32; k++) begin
            idle();
            total++; if (num !== old_num) begin bad++; $display("FAIL restart_hold k=%0d got=%h exp=%h", k, num, old_num); end
        end
        idle();
        total++; if (num !== 32'h0000_2500) begin bad++; $display("FAIL restart_num got=%h exp=%h", num, 32'h2500); end
        step(1, 0, 4'h0, 32'd7, 4'hF);
        repeat (14) idle();
        reset = 1'b1;                         // asynchronous, between edges
        #1;
        model_reset();
        total++; if (num !== 32'h0) begin bad++; $display("FAIL midreset_num got=%h exp=%h", num, 32'h0); end
        total++; if (io_rdata !== 32'h0) begin bad++; $display("FAIL midreset_rdata got=%h exp=%h", io_rdata, 32'h0); end
        @(posedge clk); #1 reset = 1'b0;
        step(0, 1, 4'h8, '0, 4'h0);
        total++; if (io_rdata !== 32'h0) begin bad++; $display("FAIL midreset_status got=%h exp=%h", io_rdata, 32'h0); end
        repeat (40) idle();
        total++; if (num !== 32'h0) begin bad++; $display("FAIL midreset_no_result got=%h exp=%h", num, 32'h0); end
    endtask

    task automatic test_mode_switch();
        step(1, 0, 4'h0, 32'd255, 4'hF);
        total++; if (num !== 32'h0000_00FF) begin bad++; $display("FAIL mode_hex got=%h exp=%h", num, 32'hFF); end
        step(1, 0, 4'h4, 32'h1, 4'h1);
        repeat (33) idle();
        total++; if (num !== 32'h0000_0255) begin bad++; $display("FAIL mode_dec got=%h exp=%h", num, 32'h255); end
        step(1, 0, 4'h4, 32'h0, 4'h1);
        total++; if (num !== 32'h0000_00FF) begin bad++; $display("FAIL mode_back got=%h exp=%h", num, 32'hFF); end
        // CTRL write without byte 0 enabled leaves dec alone
        step(1, 0, 4'h4, 32'h1, 4'hE);
        step(0, 1, 4'h4, '0, 4'h0);
        total++; if (io_rdata !== 32'h0) begin bad++; $display("FAIL mode_masked_ctrl got=%h exp=%h", io_rdata, 32'h0); end
    endtask

    task automatic test_random();
        int errs_before = bad;
        for (int n = 0; n < 2000; n++) begin
            logic wr, rd;
            logic [3:0] addr, wm;
            logic [31:0] wd;
            wr   = ($urandom_range(0, 9) == 0);
            rd   = ($urandom_range(0, 2) == 0);
            addr = {$urandom_range(0, 3), 2'b00};
            if ($urandom_range(0, 3) == 0) addr[1:0] = $urandom_range(0, 3);
            wm   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            case ($urandom_range(0, 3))
                0: wd = $urandom;
                1: wd = $urandom_range(99999990, 100000010);
                default: wd = $urandom_range(0, 99999999);
            endcase
            if (addr[3:2] == 2'd1 && $urandom_range(0, 3) != 0) wr = 1'b0;  // fewer mode flips
            step(wr, rd, addr, wd, wm);
            total++; if (num !== m_num) begin bad++; $display("FAIL rand_num n=%0d got=%h exp=%h", n, num, m_num); end
            total++; if (io_rdata !== m_rdata) begin bad++; $display("FAIL rand_rdata n=%0d got=%h exp=%h", n, io_rdata, m_rdata); end
            if (bad - errs_before > 20) break;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_hex_write();
        test_byte_mask();
        test_decimal();
        test_saturation();
        test_back_to_back();
        test_mode_switch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
